imem_load_ctrl: RTL and testbench

- Sequencer for the MIPS program memory and core run control.
- Takes a byte stream from the UART receiver and decodes command bytes.
- Assembles 32-bit instruction words and drives the program-memory write port.
- Then gates the core clock-enable for continuous run or single-step, stopping on HALT.
- Sits between the UART RX and the instruction memory / pipeline top.

---
 rtl/imem_load_ctrl.sv | 162 ++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// UART-driven program loader and core run control for the MIPS instruction memory.
// Optional load inactivity timeout is enabled with `define IMEM_LOAD_TIMEOUT_EN.
module imem_load_ctrl #(
  parameter int unsigned          len_addr  = 32,
  parameter int unsigned          len_data  = 32,
  parameter int unsigned          ram_depth = 2048,
  parameter logic [len_data-1:0]  halt_word = 32'hFFFFFFFF
`ifdef IMEM_LOAD_TIMEOUT_EN
  , parameter int unsigned        timeout_cycles = 1_000_000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  input  logic                halt_fetched_i,
  output logic                mem_we_o,
  output logic [len_addr-1:0] mem_waddr_o,
  output logic [len_data-1:0] mem_wdata_o,
  output logic                cpu_en_o,
  output logic                cpu_rst_o,
  output logic                busy_o,
  output logic                load_err_o,
  output logic [len_addr-1:0] word_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_STEP} state_t;

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_N = 8'h4E;
  localparam logic [7:0] CMD_E = 8'h45;
  localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(ram_depth - 1);

  state_t              state_q;
  logic [1:0]          byte_idx_q;
  logic [len_data-9:0] asm_q;        // first three bytes of the word being assembled
  logic                mem_we_q;
  logic [len_addr-1:0] mem_waddr_q;
  logic [len_data-1:0] mem_wdata_q;
  logic                cpu_en_q;
  logic                cpu_rst_q;
  logic                load_err_q;
  logic [len_addr-1:0] word_cnt_q;
  logic                loaded_q;     // a load has ended on halt_word since reset
`ifdef IMEM_LOAD_TIMEOUT_EN
  logic [31:0]         tmo_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_en_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
      load_err_q  <= 1'b0;
      word_cnt_q  <= '0;
      loaded_q    <= 1'b0;
`ifdef IMEM_LOAD_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cpu_en_q <= 1'b0;
          if (rx_valid_i) begin
            case (rx_data_i)
              CMD_L: begin
                state_q     <= S_LOAD;
                mem_waddr_q <= '0;
                word_cnt_q  <= '0;
                byte_idx_q  <= '0;
                load_err_q  <= 1'b0;
                cpu_rst_q   <= 1'b1;
`ifdef IMEM_LOAD_TIMEOUT_EN
                tmo_q       <= '0;
`endif
              end
              CMD_R: begin
                state_q  <= S_RUN;
                cpu_en_q <= 1'b1;
              end
              CMD_S:   state_q <= S_STEP;
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          cpu_en_q <= 1'b0;
          // Retire the word written last cycle; the halt address stays in mem_waddr.
          if (mem_we_q) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (mem_wdata_q == halt_word) begin
              state_q   <= S_IDLE;
              loaded_q  <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else if (mem_waddr_q == LAST_ADDR) begin
              state_q    <= S_IDLE;
              load_err_q <= 1'b1;
              cpu_rst_q  <= ~loaded_q;
            end else begin
              mem_waddr_q <= mem_waddr_q + 1'b1;
            end
          end
          if (rx_valid_i) begin
            asm_q      <= {asm_q[len_data-17:0], rx_data_i};
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= {asm_q, rx_data_i};
            end
`ifdef IMEM_LOAD_TIMEOUT_EN
            tmo_q <= '0;
          end else if (tmo_q == 32'(timeout_cycles - 1)) begin
            state_q    <= S_IDLE;
            load_err_q <= 1'b1;
            byte_idx_q <= '0;
            cpu_rst_q  <= ~loaded_q;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        S_RUN: begin
          if (halt_fetched_i) begin
            cpu_en_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cpu_en_q <= 1'b1;
          end
        end
        S_STEP: begin
          cpu_en_q <= 1'b0;
          // A halt drops any byte arriving in the same cycle.
          if (halt_fetched_i) begin
            state_q <= S_IDLE;
          end else if (rx_valid_i) begin
            if (rx_data_i == CMD_N) cpu_en_q <= 1'b1;
            else if (rx_data_i == CMD_E) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we_o     = mem_we_q;
  assign mem_waddr_o  = mem_waddr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign cpu_en_o     = cpu_en_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign busy_o       = (state_q != S_IDLE);
  assign load_err_o   = load_err_q;
  assign word_count_o = word_cnt_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized bench for imem_load_ctrl with a word-list reference model of loads.
module tb_imem_load_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halt_fetched;
  logic        mem_we_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic        cpu_en_o;
  logic        cpu_rst_o;
  logic        busy_o;
  logic        load_err_o;
  logic [31:0] word_count_o;

  imem_load_ctrl #(
    .ram_depth(DEPTH)
`ifdef IMEM_LOAD_TIMEOUT_EN
    , .timeout_cycles(100)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .halt_fetched_i(halt_fetched), .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .cpu_en_o(cpu_en_o), .cpu_rst_o(cpu_rst_o),
    .busy_o(busy_o), .load_err_o(load_err_o), .word_count_o(word_count_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         wr_q[$];
  wr_t         mon_t;
  logic [31:0] exp_w[$];
  int          nvec = 0;
  int          nerr = 0;

  // Every cycle with mem_we high is one observed write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we_o === 1'b1) begin
      mon_t.a = mem_waddr_o;
      mon_t.d = mem_wdata_o;
      wr_q.push_back(mon_t);
    end
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_words(input int gmax);
    logic [31:0] w;
    for (int i = 0; i < exp_w.size(); i++) begin
      w = exp_w[i];
      for (int b = 3; b >= 0; b--) begin
        send(w[8*b +: 8]);
        idle($urandom_range(0, gmax));
      end
    end
  endtask

  task automatic test_reset;
    nvec++;
    if ({mem_we_o, cpu_en_o, cpu_rst_o, busy_o, load_err_o} !== 5'b00100) begin
      nerr++; $display("FAIL reset_ctrl: got %b want 00100",
                       {mem_we_o, cpu_en_o, cpu_rst_o, busy_o, load_err_o});
    end
    nvec++;
    if ({mem_waddr_o, mem_wdata_o, word_count_o} !== 96'd0) begin
      nerr++; $display("FAIL reset_data: got %h %h %h want 0", mem_waddr_o, mem_wdata_o, word_count_o);
    end
    rst_n = 1'b1;
    idle(2);
    nvec++;
    if (cpu_rst_o !== 1'b1 || busy_o !== 1'b0) begin
      nerr++; $display("FAIL idle_no_load: got rst=%b busy=%b want 1 0", cpu_rst_o, busy_o);
    end
  endtask

  task automatic test_load_basic;
    wr_q.delete();
    exp_w = '{32'h00000020, 32'h24010005, 32'hFFFFFFFF};
    send(8'h4C);
    nvec++;
    if (busy_o !== 1'b1 || cpu_rst_o !== 1'b1 || cpu_en_o !== 1'b0) begin
      nerr++; $display("FAIL load_enter: got busy=%b rst=%b en=%b want 1 1 0", busy_o, cpu_rst_o, cpu_en_o);
    end
    send_words(0);
    idle(2);
    nvec++;
    if (wr_q.size() != 3) begin
      nerr++; $display("FAIL basic_nwrites: got %0d want 3", wr_q.size());
    end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      nvec++;
      if (wr_q[i].a !== 32'(i) || wr_q[i].d !== exp_w[i]) begin
        nerr++; $display("FAIL basic_write%0d: got %h@%0d want %h@%0d", i, wr_q[i].d, wr_q[i].a, exp_w[i], i);
      end
    end
    nvec++;
    if (word_count_o !== 32'd3 || load_err_o !== 1'b0 || busy_o !== 1'b0 ||
        cpu_rst_o !== 1'b0 || mem_waddr_o !== 32'd2) begin
      nerr++; $display("FAIL basic_end: got wc=%0d err=%b busy=%b rst=%b addr=%0d want 3 0 0 0 2",
                       word_count_o, load_err_o, busy_o, cpu_rst_o, mem_waddr_o);
    end
  endtask

  task automatic test_run(input int len);
    int cnt = 0;
    send(8'h52);
    for (int i = 0; i < len; i++) begin
      if (cpu_en_o === 1'b1) cnt++;
      rx_valid = (i == 2);
      rx_data  = (i == 2) ? 8'h4C : 8'h00;
      if (i == len - 1) halt_fetched = 1'b1;
      @(negedge clk);
    end
    halt_fetched = 1'b0;
    rx_valid = 1'b0;
    nvec++;
    if (cnt != len) begin
      nerr++; $display("FAIL run_en_cycles: got %0d want %0d", cnt, len);
    end
    nvec++;
    if (cpu_en_o !== 1'b0 || busy_o !== 1'b0) begin
      nerr++; $display("FAIL run_halt: got en=%b busy=%b want 0 0", cpu_en_o, busy_o);
    end
    idle(1);
    nvec++;
    if (cpu_en_o !== 1'b0) begin
      nerr++; $display("FAIL run_after: got en=%b want 0", cpu_en_o);
    end
  endtask

  task automatic test_step;
    send(8'h53);
    nvec++;
    if (busy_o !== 1'b1 || cpu_en_o !== 1'b0) begin
      nerr++; $display("FAIL step_enter: got busy=%b en=%b want 1 0", busy_o, cpu_en_o);
    end
    for (int k = 0; k < 3; k++) begin
      idle($urandom_range(1, 3));
      send(8'h4E);
      nvec++;
      if (cpu_en_o !== 1'b1) begin
        nerr++; $display("FAIL step_pulse%0d: got %b want 1", k, cpu_en_o);
      end
      idle(1);
      nvec++;
      if (cpu_en_o !== 1'b0) begin
        nerr++; $display("FAIL step_pulse_end%0d: got %b want 0", k, cpu_en_o);
      end
    end
    send(8'h45);
    nvec++;
    if (busy_o !== 1'b0) begin
      nerr++; $display("FAIL step_exit: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_step_halt;
    send(8'h53);
    send(8'h4E);
    halt_fetched = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h4E;
    @(negedge clk);
    halt_fetched = 1'b0;
    rx_valid = 1'b0;
    nvec++;
    if (busy_o !== 1'b0 || cpu_en_o !== 1'b0) begin
      nerr++; $display("FAIL step_halt: got busy=%b en=%b want 0 0", busy_o, cpu_en_o);
    end
    idle(1);
    nvec++;
    if (cpu_en_o !== 1'b0) begin
      nerr++; $display("FAIL step_halt_drop: got en=%b want 0", cpu_en_o);
    end
  endtask

  // Model: the load writes words in order until halt_word or the last entry.
  task automatic test_random_loads(input int iters);
    int h, n;
    logic [31:0] w;
    for (int it = 0; it < iters; it++) begin
      wr_q.delete();
      exp_w.delete();
      h = $urandom_range(0, DEPTH);
      n = (h < DEPTH) ? h + 1 : DEPTH;
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if (w == 32'hFFFFFFFF) w = 32'h0;
        if (i == h) w = 32'hFFFFFFFF;
        exp_w.push_back(w);
      end
      send(8'h4C);
      send_words(2);
      idle(2);
      nvec++;
      if (wr_q.size() != n) begin
        nerr++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, wr_q.size(), n);
      end
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
        nvec++;
        if (wr_q[i].a !== 32'(i) || wr_q[i].d !== exp_w[i]) begin
          nerr++; $display("FAIL rnd%0d_write%0d: got %h@%0d want %h@%0d", it, i, wr_q[i].d, wr_q[i].a, exp_w[i], i);
        end
      end
      nvec++;
      if (word_count_o !== 32'(n) || load_err_o !== (h == DEPTH) || busy_o !== 1'b0) begin
        nerr++; $display("FAIL rnd%0d_end: got wc=%0d err=%b busy=%b want %0d %b 0",
                         it, word_count_o, load_err_o, busy_o, n, (h == DEPTH));
      end
      if (h < DEPTH) begin
        nvec++;
        if (mem_waddr_o !== 32'(h)) begin
          nerr++; $display("FAIL rnd%0d_haltaddr: got %0d want %0d", it, mem_waddr_o, h);
        end
      end
    end
  endtask

  task automatic test_overflow;
    wr_q.delete();
    send(8'h4C);
    for (int i = 1; i <= 16; i++) send(8'(i));
    idle(3);
    for (int i = 17; i <= 20; i++) send(8'(i));
    idle(2);
    nvec++;
    if (wr_q.size() != 4) begin
      nerr++; $display("FAIL ovf_nwrites: got %0d want 4", wr_q.size());
    end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      nvec++;
      w_chk: if (wr_q[i].a !== 32'(i) ||
                 wr_q[i].d !== {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)}) begin
        nerr++; $display("FAIL ovf_write%0d: got %h@%0d", i, wr_q[i].d, wr_q[i].a);
      end
    end
    nvec++;
    if (load_err_o !== 1'b1 || busy_o !== 1'b0 || word_count_o !== 32'd4) begin
      nerr++; $display("FAIL ovf_end: got err=%b busy=%b wc=%0d want 1 0 4", load_err_o, busy_o, word_count_o);
    end
    send(8'h53);
    send(8'h45);
    nvec++;
    if (load_err_o !== 1'b1) begin
      nerr++; $display("FAIL err_sticky: got %b want 1", load_err_o);
    end
    send(8'h4C);
    nvec++;
    if (load_err_o !== 1'b0) begin
      nerr++; $display("FAIL err_clear: got %b want 0", load_err_o);
    end
    exp_w = '{32'hFFFFFFFF};
    send_words(0);
    idle(2);
  endtask

  task automatic test_reset_midword;
    wr_q.delete();
    send(8'h4C);
    send(8'hAA);
    send(8'hBB);
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({mem_we_o, cpu_en_o, cpu_rst_o, busy_o, load_err_o} !== 5'b00100 ||
        {mem_waddr_o, mem_wdata_o, word_count_o} !== 96'd0) begin
      nerr++; $display("FAIL midreset: got ctl=%b addr=%h data=%h wc=%h",
                       {mem_we_o, cpu_en_o, cpu_rst_o, busy_o, load_err_o}, mem_waddr_o, mem_wdata_o, word_count_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    exp_w = '{32'h11223344, 32'hFFFFFFFF};
    send(8'h4C);
    send_words(1);
    idle(2);
    nvec++;
    if (wr_q.size() != 2) begin
      nerr++; $display("FAIL midreset_nwrites: got %0d want 2", wr_q.size());
    end
    for (int i = 0; i < 2 && i < wr_q.size(); i++) begin
      nvec++;
      if (wr_q[i].a !== 32'(i) || wr_q[i].d !== exp_w[i]) begin
        nerr++; $display("FAIL midreset_write%0d: got %h@%0d want %h@%0d", i, wr_q[i].d, wr_q[i].a, exp_w[i], i);
      end
    end
  endtask

`ifdef IMEM_LOAD_TIMEOUT_EN
  task automatic test_timeout;
    wr_q.delete();
    send(8'h4C);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    idle(95);
    nvec++;
    if (busy_o !== 1'b1) begin
      nerr++; $display("FAIL tmo_early: got busy=%b want 1", busy_o);
    end
    idle(10);
    nvec++;
    if (busy_o !== 1'b0 || load_err_o !== 1'b1 || wr_q.size() != 0) begin
      nerr++; $display("FAIL tmo_end: got busy=%b err=%b writes=%0d want 0 1 0", busy_o, load_err_o, wr_q.size());
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    halt_fetched = 1'b0;
    idle(2);
    test_reset();
    test_load_basic();
    test_run(10);
    test_run($urandom_range(5, 20));
    test_step();
    test_step_halt();
    test_random_loads(8);
    test_overflow();
    test_reset_midword();
`ifdef IMEM_LOAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
